// File: rtl/fpga_link_pkg.sv
// rtl/fpga_link_pkg.sv - shared states, defaults and beat helper for the inter-FPGA link receiver
package fpga_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_ACK_HOLD = 3'd3,
    ST_END_ACK  = 3'd4
  } rx_state_e;

  localparam int unsigned DEF_LANES          = 1;
  localparam int unsigned DEF_WORD_WIDTH     = 8;
  localparam int unsigned DEF_MAX_WORDS      = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  // Number of handshake beats needed to assemble one word.
  function automatic int unsigned beats_per_word(input int unsigned lanes,
                                                 input int unsigned word_width);
    return word_width / lanes;
  endfunction

endpackage

// File: rtl/fpga_link_sync.sv
// rtl/fpga_link_sync.sv - two-flop synchroniser for asynchronous link strobes
module fpga_link_sync (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fpga_link_receiver.sv
// rtl/fpga_link_receiver.sv - parametrised inter-FPGA link receiver; FPGA_RX_PARITY_EN adds a per-beat parity check
module fpga_link_receiver
  import fpga_link_pkg::*;
#(
  parameter int unsigned LANES          = DEF_LANES,
  parameter int unsigned WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int unsigned MAX_WORDS      = DEF_MAX_WORDS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           send,
  input  logic                           finish,
  input  logic [LANES-1:0]               data,
`ifdef FPGA_RX_PARITY_EN
  input  logic                           parity,
`endif
  input  logic                           out_ready,
  output logic                           acknowledge,
  output logic [WORD_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  output logic                           frame_done,
  output logic [$clog2(MAX_WORDS+1)-1:0] frame_words,
  output logic                           frame_error,
  output logic                           busy
);

  localparam int unsigned BEATS = beats_per_word(LANES, WORD_WIDTH);
  localparam int unsigned BW    = $clog2(BEATS + 1);
  localparam int unsigned CW    = $clog2(MAX_WORDS + 1);
  localparam int unsigned TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned PW    = (WORD_WIDTH > LANES) ? WORD_WIDTH - LANES : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [CW-1:0] WORD_MAX  = CW'(MAX_WORDS);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit            TMO_EN    = (TIMEOUT_CYCLES > 0);

  rx_state_e             state_q;
  logic                  ack_q;
  logic                  out_valid_q;
  logic [WORD_WIDTH-1:0] out_data_q;
  logic                  frame_done_q;
  logic                  frame_error_q;
  logic [CW-1:0]         frame_words_q;
  logic [BW-1:0]         beat_q;
  logic [CW-1:0]         word_q;
  logic                  ovf_q;
  logic                  bad_q;
  logic [TW-1:0]         tmo_q;
  logic [PW-1:0]         part_q;

  logic                  send_s;
  logic                  finish_s;
  logic                  par_err_c;
  logic                  slot_free_c;
  logic                  stay_c;
  logic                  tmo_abort_c;
  logic [WORD_WIDTH-1:0] word_d;

  fpga_link_sync u_sync_send   (.clock(clock), .reset(reset), .d_i(send),   .q_o(send_s));
  fpga_link_sync u_sync_finish (.clock(clock), .reset(reset), .d_i(finish), .q_o(finish_s));

`ifdef FPGA_RX_PARITY_EN
  logic parity_s;
  fpga_link_sync u_sync_parity (.clock(clock), .reset(reset), .d_i(parity), .q_o(parity_s));
  assign par_err_c = parity_s ^ (^data);
`else
  assign par_err_c = 1'b0;
`endif

  // Only the not-yet-complete part of a word is kept; the newest lanes enter at the LSB end.
  if (WORD_WIDTH > LANES) begin : g_shift
    assign word_d = {part_q, data};
  end else begin : g_single
    assign word_d = data;
  end

  // Stall/timeout qualifiers: a state that holds without progress accrues idle time.
  always_comb begin
    slot_free_c = !out_valid_q || out_ready;
    stay_c      = ((state_q == ST_WAIT) && !(send_s && slot_free_c) && !(!send_s && finish_s)) ||
                  ((state_q == ST_ACK_HOLD) && send_s);
    tmo_abort_c = TMO_EN && stay_c && (tmo_q == TMO_LAST);
  end

  // Receiver FSM with registered handshake, word, frame and error outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ack_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      frame_words_q <= '0;
      beat_q        <= '0;
      word_q        <= '0;
      ovf_q         <= 1'b0;
      bad_q         <= 1'b0;
      tmo_q         <= '0;
      part_q        <= '0;
    end else begin
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      tmo_q         <= stay_c ? tmo_q + 1'b1 : '0;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          if (send_s) begin
            state_q <= ST_WAIT;
            beat_q  <= '0;
            word_q  <= '0;
            ovf_q   <= 1'b0;
            bad_q   <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (send_s) begin
            if (slot_free_c) state_q <= ST_CAPTURE;
          end else if (finish_s) begin
            state_q <= ST_END_ACK;
            ack_q   <= 1'b1;
            if ((beat_q == '0) && !ovf_q && !bad_q) begin
              frame_done_q  <= 1'b1;
              frame_words_q <= word_q;
            end else begin
              frame_error_q <= 1'b1;
            end
            beat_q <= '0;
            word_q <= '0;
            ovf_q  <= 1'b0;
            bad_q  <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          state_q <= ST_ACK_HOLD;
          ack_q   <= 1'b1;
          part_q  <= word_d[PW-1:0];
          if (par_err_c) bad_q <= 1'b1;
          if (beat_q == BEAT_LAST) begin
            beat_q <= '0;
            if (word_q == WORD_MAX) begin
              ovf_q <= 1'b1;
            end else begin
              out_data_q  <= word_d;
              out_valid_q <= 1'b1;
              word_q      <= word_q + 1'b1;
            end
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        ST_ACK_HOLD: begin
          if (!send_s) begin
            state_q <= ST_WAIT;
            ack_q   <= 1'b0;
          end
        end
        ST_END_ACK: begin
          if (!finish_s) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
      endcase

      // A stalled remote aborts the frame; a word already offered downstream survives.
      if (tmo_abort_c) begin
        state_q       <= ST_IDLE;
        ack_q         <= 1'b0;
        frame_error_q <= 1'b1;
        beat_q        <= '0;
        word_q        <= '0;
        ovf_q         <= 1'b0;
        bad_q         <= 1'b0;
        tmo_q         <= '0;
      end
    end
  end

  assign acknowledge = ack_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign frame_words = frame_words_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpga_link_receiver.sv
// tb/tb_fpga_link_receiver.sv - randomized frame-level bench for fpga_link_receiver (FPGA_RX_PARITY_EN aware)
module tb_fpga_link_receiver;

  localparam int LANES = 4;
  localparam int WW    = 8;
  localparam int MAXW  = 4;
  localparam int TMO   = 16;
  localparam int FW    = $clog2(MAXW + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             send = 1'b0;
  logic             finish = 1'b0;
  logic             out_ready = 1'b0;
  logic [LANES-1:0] data = '0;
`ifdef FPGA_RX_PARITY_EN
  logic             parity = 1'b0;
  logic             par_flip = 1'b0;
`endif
  logic             acknowledge;
  logic             out_valid;
  logic             frame_done;
  logic             frame_error;
  logic             busy;
  logic [WW-1:0]    out_data;
  logic [FW-1:0]    frame_words;

  int errors = 0;
  int checks = 0;
  int ready_mode = 2;
  int done_cnt = 0;
  int err_cnt = 0;
  int exp_fw = 0;
  logic [WW-1:0] got_q[$];
  logic [WW-1:0] exp_q[$];
  logic [3:0]    beat_buf[16];
  logic          prev_hold = 1'b0;
  logic [WW-1:0] prev_data = '0;
  logic          mon_r;

  always #5 clock = ~clock;

  fpga_link_receiver #(
    .LANES(LANES), .WORD_WIDTH(WW), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .send(send), .finish(finish), .data(data),
`ifdef FPGA_RX_PARITY_EN
    .parity(parity),
`endif
    .out_ready(out_ready), .acknowledge(acknowledge), .out_data(out_data),
    .out_valid(out_valid), .frame_done(frame_done), .frame_words(frame_words),
    .frame_error(frame_error), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer and frame-pulse monitor, all on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      prev_hold = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (prev_hold) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, prev_data);
      end
      mon_r = (ready_mode == 2) ? 1'b1 : (ready_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      out_ready = mon_r;
      if (out_valid && mon_r) got_q.push_back(out_data);
      prev_hold = out_valid && !mon_r;
      prev_data = out_data;
      if (frame_done) done_cnt++;
      if (frame_error) err_cnt++;
    end
  end

  task automatic wait_ack(input logic lvl, input int budget, output int n);
    n = 0;
    while (acknowledge !== lvl && n < budget) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic drive_data(input logic [3:0] v);
    data = v;
`ifdef FPGA_RX_PARITY_EN
    parity = (^v) ^ par_flip;
`endif
  endtask

  task automatic send_beat(input logic [3:0] v, input bit first);
    int n;
    bit lat;
    lat = (ready_mode == 2);
    drive_data(v);
    send = 1'b1;
    wait_ack(1'b1, 60, n);
    check_eq("ack_rise", acknowledge, 1);
    if (lat && acknowledge === 1'b1) check_eq("ack_latency", n, first ? 5 : 4);
    send = 1'b0;
    wait_ack(1'b0, 60, n);
    check_eq("ack_fall", acknowledge, 0);
  endtask

  task automatic end_frame();
    int n;
    finish = 1'b1;
    wait_ack(1'b1, 60, n);
    check_eq("fin_ack_rise", acknowledge, 1);
    finish = 1'b0;
    wait_ack(1'b0, 60, n);
    check_eq("fin_ack_fall", acknowledge, 0);
  endtask

  task automatic drain_and_check(input int d0, input int e0, input bit ok);
    for (int i = 0; i < 100 && out_valid; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    check_eq("busy_after", busy, 0);
    check_eq("n_words", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check_eq("word", got_q[k], exp_q[k]);
    check_eq("done_pulses", done_cnt - d0, ok ? 1 : 0);
    check_eq("err_pulses", err_cnt - e0, ok ? 0 : 1);
    check_eq("frame_words", frame_words, exp_fw);
  endtask

  // Frame reference: beats pair up MSB-first into words; odd beats or too many words spoil the frame.
  task automatic run_frame(input int nb, input int bad_beat);
    int d0, e0, nw;
    bit ok;
    got_q.delete();
    exp_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < nb; i++) begin
`ifdef FPGA_RX_PARITY_EN
      par_flip = (i == bad_beat);
`endif
      send_beat(beat_buf[i], i == 0);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
`ifdef FPGA_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    end_frame();
    nw = nb / (WW / LANES);
    ok = (nb % (WW / LANES) == 0) && (nw <= MAXW);
    if (bad_beat >= 0 && bad_beat < nb) ok = 1'b0;
    if (nw > MAXW) nw = MAXW;
    for (int k = 0; k < nw; k++) exp_q.push_back({beat_buf[2*k], beat_buf[2*k+1]});
    if (ok) exp_fw = nb / (WW / LANES);
    drain_and_check(d0, e0, ok);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, e0, nb;
    repeat (3) @(negedge clock);
    check_eq("rst_ack", acknowledge, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_words", frame_words, 0);
    check_eq("rst_error", frame_error, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    ready_mode = 2;
    beat_buf[0] = 4'hA; beat_buf[1] = 4'h5;
    run_frame(2, -1);
    beat_buf[0] = 4'h1; beat_buf[1] = 4'h2; beat_buf[2] = 4'h3; beat_buf[3] = 4'h4;
    run_frame(4, -1);

    // Backpressure: full output slot must hold off the next beat's acknowledge.
    ready_mode = 1;
    got_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    send_beat(4'h1, 1'b1);
    send_beat(4'h2, 1'b0);
    repeat (2) @(negedge clock);
    check_eq("bp_valid", out_valid, 1);
    check_eq("bp_data", out_data, 8'h12);
    drive_data(4'h3);
    send = 1'b1;
    repeat (10) @(negedge clock);
    check_eq("bp_ack_low", acknowledge, 0);
    check_eq("bp_busy", busy, 1);
    ready_mode = 2;
    wait_ack(1'b1, 60, n);
    check_eq("bp_ack_rise", acknowledge, 1);
    send = 1'b0;
    wait_ack(1'b0, 60, n);
    send_beat(4'h4, 1'b0);
    end_frame();
    exp_q.delete();
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    exp_fw = 2;
    drain_and_check(d0, e0, 1'b1);

    // Partial word and overflow.
    beat_buf[0] = 4'h1; beat_buf[1] = 4'h2; beat_buf[2] = 4'h3;
    run_frame(3, -1);
    for (int i = 0; i < 10; i++) beat_buf[i] = 4'(i + 1);
    run_frame(10, -1);

`ifdef FPGA_RX_PARITY_EN
    beat_buf[0] = 4'h9; beat_buf[1] = 4'hC;
    run_frame(2, 0);
`endif

    // Timeout after a lone beat.
    e0 = err_cnt;
    send_beat(4'h7, 1'b1);
    n = 0;
    while (!frame_error && n < 40) begin
      @(negedge clock);
      n++;
    end
    check_eq("tmo_latency", n, TMO);
    check_eq("tmo_busy", busy, 0);
    check_eq("tmo_ack", acknowledge, 0);
    @(negedge clock);
    check_eq("tmo_err_pulse", err_cnt - e0, 1);
    beat_buf[0] = 4'hC; beat_buf[1] = 4'h3;
    run_frame(2, -1);

    // Asynchronous reset while holding acknowledge with a word pending.
    ready_mode = 1;
    send_beat(4'h5, 1'b1);
    drive_data(4'h6);
    send = 1'b1;
    wait_ack(1'b1, 60, n);
    check_eq("rst_pre_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_ack", acknowledge, 0);
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_data", out_data, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_words", frame_words, 0);
    send = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_fw = 0;
    ready_mode = 2;
    repeat (2) @(negedge clock);

    // Randomized frames with a random consumer.
    ready_mode = 0;
    for (int f = 0; f < 12; f++) begin
      nb = $urandom_range(1, 11);
      for (int i = 0; i < nb; i++) beat_buf[i] = 4'($urandom);
      run_frame(nb, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
